// File: rtl/rcosine_rx_sampler_pkg.sv
// Shared definitions for the raised-cosine TX filter and RX sampler.
// Holds the default datapath constants, the RX state encoding and a
// constant-friendly log2 helper used for sizing counters.
package rcosine_pkg;

    typedef enum logic [1:0] {
        ST_ACQ  = 2'd0,
        ST_SEL  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int DEF_DW       = 19;
    localparam int DEF_OSR      = 4;
    localparam int DEF_ACQ_SYMS = 16;
    localparam int DEF_MID      = 71808;
    localparam int DEF_SHIFT    = 15;
    localparam int DEF_SYM_W    = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rcosine_rx_sampler_if.sv
// Sample-in / symbol-out bundle of the RX sampler.
// master = upstream filter side plus symbol consumer, slave = the sampler.
interface rcosine_rx_sampler_if
    import rcosine_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int OSR   = DEF_OSR,
    parameter int SYM_W = DEF_SYM_W
);
    localparam int PW = clog2(OSR);

    logic [DW-1:0]    din;
    logic             din_valid;
    logic             restart;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             locked;
    logic [PW-1:0]    phase;

    modport master (
        output din, din_valid, restart,
        input  sym_out, sym_valid, locked, phase
    );

    modport slave (
        input  din, din_valid, restart,
        output sym_out, sym_valid, locked, phase
    );

endinterface

// File: rtl/rcosine_rx_sampler_slicer.sv
// Combinational front end of the RX sampler: deviation of the incoming
// sample from the zero level, and the saturated symbol slice.
module rcosine_rx_slicer
    import rcosine_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int MID   = DEF_MID,
    parameter int SHIFT = DEF_SHIFT,
    parameter int SYM_W = DEF_SYM_W
) (
    input  logic [DW-1:0]    i_din,
    output logic [DW-1:0]    o_dev,
    output logic [SYM_W-1:0] o_sym
);
    localparam logic [DW-1:0] MID_V   = DW'(MID);
    localparam logic [DW-1:0] SYM_MAX = DW'((1 << SYM_W) - 1);

    logic [DW-1:0] w_shifted;

    // Absolute deviation and shifted value clamped to the largest symbol code
    always_comb begin
        o_dev     = (i_din >= MID_V) ? (i_din - MID_V) : (MID_V - i_din);
        w_shifted = i_din >> SHIFT;
        o_sym     = (w_shifted > SYM_MAX) ? SYM_MAX[SYM_W-1:0] : w_shifted[SYM_W-1:0];
    end

endmodule

// File: rtl/rcosine_rx_sampler.sv
// RX symbol sampler: accumulates per-phase energy for ACQ_SYMS symbols,
// picks the strongest phase (lowest index on ties), then decimates by OSR
// and emits one sliced symbol per chosen-phase sample.
module rcosine_rx_sampler
    import rcosine_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int OSR      = DEF_OSR,
    parameter int ACQ_SYMS = DEF_ACQ_SYMS,
    parameter int MID      = DEF_MID,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int SYM_W    = DEF_SYM_W
) (
    input  logic               clk,
    input  logic               n_rst,
    rcosine_rx_sampler_if.slave io_bus
);
    localparam int PW = clog2(OSR);
    localparam int SW = (clog2(ACQ_SYMS) > 0) ? clog2(ACQ_SYMS) : 1;
    localparam int AW = DW + clog2(ACQ_SYMS);
    localparam logic [PW-1:0] CNT_LAST = PW'(OSR - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(ACQ_SYMS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [PW-1:0]    r_cnt;
    logic [SW-1:0]    r_sym_cnt;
    logic [AW-1:0]    r_acc [OSR];
    logic [PW-1:0]    r_sel_idx;
    logic [AW-1:0]    r_best_val;
    logic [PW-1:0]    r_best_idx;
    logic [PW-1:0]    r_phase;
    logic             r_locked;
    logic             r_sym_valid;
    logic [SYM_W-1:0] r_sym_out;
    logic [DW-1:0]    w_dev;
    logic [SYM_W-1:0] w_sym;
    logic             w_acq_done;

    rcosine_rx_slicer #(
        .DW    (DW),
        .MID   (MID),
        .SHIFT (SHIFT),
        .SYM_W (SYM_W)
    ) u_slicer (
        .i_din (io_bus.din),
        .o_dev (w_dev),
        .o_sym (w_sym)
    );

    assign w_acq_done = io_bus.din_valid && (r_cnt == CNT_LAST) && (r_sym_cnt == SYM_LAST);

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_ACQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; restart overrides everything and goes back to acquisition
    always_comb begin
        w_next_state = r_state;
        if (io_bus.restart) begin
            w_next_state = ST_ACQ;
        end else begin
            case (r_state)
                ST_ACQ:  if (w_acq_done) w_next_state = ST_SEL;
                ST_SEL:  if (r_sel_idx == CNT_LAST) w_next_state = ST_LOCK;
                ST_LOCK: w_next_state = ST_LOCK;
                default: w_next_state = ST_ACQ;
            endcase
        end
    end

    // Phase counter, energy accumulation, max search and symbol output
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt       <= '0;
            r_sym_cnt   <= '0;
            r_sel_idx   <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_phase     <= '0;
            r_locked    <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_out   <= '0;
            for (int i = 0; i < OSR; i++) r_acc[i] <= '0;
        end else if (io_bus.restart) begin
            r_cnt       <= '0;
            r_sym_cnt   <= '0;
            r_sel_idx   <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_locked    <= 1'b0;
            r_sym_valid <= 1'b0;
            for (int i = 0; i < OSR; i++) r_acc[i] <= '0;
        end else begin
            r_sym_valid <= 1'b0;
            if (io_bus.din_valid) r_cnt <= r_cnt + PW'(1);
            case (r_state)
                ST_ACQ: begin
                    r_sel_idx  <= '0;
                    r_best_val <= '0;
                    r_best_idx <= '0;
                    if (io_bus.din_valid) begin
                        r_acc[r_cnt] <= r_acc[r_cnt] + AW'(w_dev);
                        if (r_cnt == CNT_LAST) r_sym_cnt <= r_sym_cnt + SW'(1);
                    end
                end
                ST_SEL: begin
                    r_sel_idx <= r_sel_idx + PW'(1);
                    if (r_acc[r_sel_idx] > r_best_val) begin
                        r_best_val <= r_acc[r_sel_idx];
                        r_best_idx <= r_sel_idx;
                    end
                    if (r_sel_idx == CNT_LAST) begin
                        r_phase  <= (r_acc[r_sel_idx] > r_best_val) ? r_sel_idx : r_best_idx;
                        r_locked <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (io_bus.din_valid && (r_cnt == r_phase)) begin
                        r_sym_out   <= w_sym;
                        r_sym_valid <= 1'b1;
                    end
                end
                default: begin
                    r_sel_idx <= '0;
                end
            endcase
        end
    end

    assign io_bus.sym_out   = r_sym_out;
    assign io_bus.sym_valid = r_sym_valid;
    assign io_bus.locked    = r_locked;
    assign io_bus.phase     = r_phase;

endmodule

// File: tb/tb_rcosine_rx_sampler.sv
// Testbench for rcosine_rx_sampler: a cycle-level reference model predicts
// lock state and phase, and pushes expected symbols into a scoreboard queue
// that is popped whenever a strobe is due.
`timescale 1ns/1ps
module tb_rcosine_rx_sampler;
    import rcosine_pkg::*;

    localparam int DW       = DEF_DW;
    localparam int OSR      = DEF_OSR;
    localparam int ACQ_SYMS = DEF_ACQ_SYMS;
    localparam int MID      = DEF_MID;
    localparam int SHIFT    = DEF_SHIFT;
    localparam int SYM_W    = DEF_SYM_W;
    localparam int SYM_MAXV = (1 << SYM_W) - 1;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    rcosine_rx_sampler_if #(.DW(DW), .OSR(OSR), .SYM_W(SYM_W)) bus ();

    rcosine_rx_sampler #(
        .DW(DW), .OSR(OSR), .ACQ_SYMS(ACQ_SYMS),
        .MID(MID), .SHIFT(SHIFT), .SYM_W(SYM_W)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .io_bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int mCnt, mSymCnt, mSelLeft, mPhase, mState;
    bit mLocked, mExpValid;
    int mAcc [OSR];
    int expQ [$];

    int cycleIdx = 0;
    int firstLockCycle = -1;
    int firstSym = -1;
    int dutSyms = 0;
    int lockedIdx2 = 0;
    int patIdx = 0;

    int bndVals [5] = '{0, 32767, 32768, 98304, 143055};
    int bndExp  [5] = '{0, 0, 1, 3, 3};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mCnt = 0; mSymCnt = 0; mSelLeft = 0; mPhase = 0; mState = 0;
        mLocked = 0; mExpValid = 0;
        for (int i = 0; i < OSR; i++) mAcc[i] = 0;
    endtask

    task automatic modelStep(input int d, input bit v, input bit r);
        int best;
        int s;
        if (r) begin
            mCnt = 0; mSymCnt = 0; mLocked = 0; mExpValid = 0; mState = 0;
            for (int i = 0; i < OSR; i++) mAcc[i] = 0;
        end else begin
            mExpValid = 0;
            if (mState == 0) begin
                if (v) begin
                    mAcc[mCnt] += (d >= MID) ? (d - MID) : (MID - d);
                    if (mCnt == OSR - 1) begin
                        if (mSymCnt == ACQ_SYMS - 1) begin
                            mState = 1;
                            mSelLeft = OSR;
                        end
                        mSymCnt++;
                    end
                end
            end else if (mState == 1) begin
                mSelLeft--;
                if (mSelLeft == 0) begin
                    best = 0;
                    for (int i = 1; i < OSR; i++) if (mAcc[i] > mAcc[best]) best = i;
                    mPhase = best;
                    mLocked = 1;
                    mState = 2;
                end
            end else begin
                if (v && mCnt == mPhase) begin
                    s = d >> SHIFT;
                    if (s > SYM_MAXV) s = SYM_MAXV;
                    expQ.push_back(s);
                    mExpValid = 1;
                end
            end
            if (v) mCnt = (mCnt + 1) % OSR;
        end
    endtask

    task automatic cycleCheck();
        int e;
        checkOutput("locked", bus.locked, mLocked);
        checkOutput("phase", bus.phase, mPhase);
        checkOutput("sym_valid", bus.sym_valid, mExpValid);
        if (bus.sym_valid) begin
            dutSyms++;
            if (firstSym < 0) firstSym = bus.sym_out;
        end
        if (mExpValid) begin
            e = expQ.pop_front();
            if (bus.sym_valid) checkOutput("sym_out", bus.sym_out, e);
        end
        if (bus.locked && firstLockCycle < 0) firstLockCycle = cycleIdx;
    endtask

    task automatic applyStimulus(input int d, input bit v, input bit r);
        @(negedge clk);
        cycleCheck();
        bus.din = DW'(d);
        bus.din_valid = v;
        bus.restart = r;
        modelStep(d, v, r);
        cycleIdx++;
    endtask

    function automatic int sampleFor(input int kind, input int idx);
        if (kind == 1) return (idx == 2) ? MID + 40000 : MID;
        if (kind == 2) return MID + 5000;
        return MID;
    endfunction

    task automatic doRestart(input bit v, input int kind);
        applyStimulus(sampleFor(kind, patIdx), v, 1'b1);
        patIdx = 0;
        cycleIdx = 0;
        firstLockCycle = -1;
    endtask

    task automatic feedSamples(input int n, input int maxGap, input int kind);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            for (int g = 0; g < gap; g++) applyStimulus(int'($urandom_range((1 << DW) - 1, 0)), 1'b0, 1'b0);
            if (patIdx == 2 && mLocked) lockedIdx2++;
            applyStimulus(sampleFor(kind, patIdx), 1'b1, 1'b0);
            patIdx = (patIdx + 1) % OSR;
        end
    endtask

    initial begin
        bit prevBnd;
        int bIdx;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.restart = 1'b0;
        modelReset();

        // Reset values
        #2;
        checkOutput("rst_sym_out", bus.sym_out, 0);
        checkOutput("rst_sym_valid", bus.sym_valid, 0);
        checkOutput("rst_locked", bus.locked, 0);
        checkOutput("rst_phase", bus.phase, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Steady MID: zero energy everywhere, phase 0, first symbol 2
        doRestart(1'b0, 0);
        firstSym = -1;
        feedSamples(80, 0, 0);
        checkOutput("lock_latency", firstLockCycle, 68);
        checkOutput("steady_phase", bus.phase, 0);
        checkOutput("first_sym", firstSym, 2);

        // Acquisition on the phase-2 pulse pattern
        doRestart(1'b0, 1);
        feedSamples(108, 0, 1);
        checkOutput("acq_phase", bus.phase, 2);
        checkOutput("acq_locked", bus.locked, 1);

        // Slicer boundaries at the chosen phase
        prevBnd = 0;
        bIdx = 0;
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < OSR; j++) begin
                if (patIdx == 2) begin
                    applyStimulus(bndVals[b], 1'b1, 1'b0);
                    bIdx = b;
                    prevBnd = 1;
                end else begin
                    applyStimulus(MID, 1'b1, 1'b0);
                    if (prevBnd) begin
                        checkOutput("bnd_valid", bus.sym_valid, 1);
                        checkOutput("bnd_sym", bus.sym_out, bndExp[bIdx]);
                    end
                    prevBnd = 0;
                end
                patIdx = (patIdx + 1) % OSR;
            end
        end

        // Tie: equal deviation on all phases selects phase 0
        doRestart(1'b0, 2);
        feedSamples(72, 0, 2);
        checkOutput("tie_phase", bus.phase, 0);

        // Random idle gaps between samples
        doRestart(1'b0, 1);
        dutSyms = 0;
        lockedIdx2 = 0;
        feedSamples(120, 3, 1);
        applyStimulus(MID, 1'b0, 1'b0);
        checkOutput("gap_phase", bus.phase, 2);
        checkOutput("gap_sym_count", dutSyms, lockedIdx2);

        // Restart coincident with a valid sample while locked
        doRestart(1'b1, 1);
        feedSamples(72, 0, 1);
        checkOutput("relock_latency", firstLockCycle, 68);
        checkOutput("relock_phase", bus.phase, 2);

        // Asynchronous reset in the middle of SEL
        doRestart(1'b0, 2);
        feedSamples(64, 0, 2);
        applyStimulus(MID, 1'b0, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("arst_locked", bus.locked, 0);
        checkOutput("arst_phase", bus.phase, 0);
        checkOutput("arst_sym_valid", bus.sym_valid, 0);
        modelReset();
        expQ.delete();
        @(negedge clk);
        n_rst = 1'b1;
        patIdx = 0;
        cycleIdx = 0;
        firstLockCycle = -1;
        feedSamples(72, 0, 1);
        checkOutput("post_rst_latency", firstLockCycle, 68);
        checkOutput("post_rst_phase", bus.phase, 2);

        applyStimulus(MID, 1'b0, 1'b0);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcosine_rx_sampler.md
Name: rcosine_rx_sampler

Overview:
- Receive-side counterpart to the team's raised-cosine pulse-shaping FIR.
- Consumes the oversampled, filtered sample stream and acquires the optimum symbol-sampling phase by per-phase energy accumulation.
- Once acquired, decimates by OSR and slices each chosen sample to a SYM_W-bit symbol.
- Sits between the filter output and the symbol deframer.

Parameters:
- DW, 19: input sample width; unsigned, matches the filter output width.
- OSR, 4: samples per symbol. Power of 2, at least 2.
- ACQ_SYMS, 16: symbols accumulated per phase during acquisition. Power of 2.
- MID, 71808: unsigned sample value for zero deviation (filter DC gain 561 × 128).
- SHIFT, 15: right shift applied before slicing.
- SYM_W, 2: output symbol width.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- din  in  DW  filtered sample
- din_valid  in  1  din qualifier; may have arbitrary gaps
- restart  in  1  synchronous pulse; forces re-acquisition
- sym_out  out  SYM_W  sliced symbol
- sym_valid  out  1  one-cycle strobe per symbol
- locked  out  1  high while in LOCK
- phase  out  clog2(OSR)  selected sampling phase

Behaviour:
- Reset values (n_rst low, asynchronous): sym_out=0, sym_valid=0, locked=0, phase=0. Internally: cnt=0, sym_cnt=0, all accumulators 0, state=ACQ.
- Phase counter cnt (0..OSR-1):
  - Advances by 1 on each din_valid and wraps OSR-1 → 0.
  - Runs in every state and never stalls.
  - Never advances in cycles without din_valid.
- Deviation: dev = |din − MID|, width DW.
- Accumulators: acc[0..OSR-1], width DW+clog2(ACQ_SYMS). They cannot overflow.
- ACQ state:
  - On din_valid: acc[cnt] += dev.
  - On each din_valid with cnt==OSR-1: sym_cnt++.
  - On the din_valid that completes sym_cnt==ACQ_SYMS-1 at cnt==OSR-1: next state is SEL. ACQ therefore consumes exactly OSR×ACQ_SYMS valid samples.
- SEL state:
  - Takes OSR clk cycles, independent of din_valid.
  - Compares one accumulator per cycle, index 0..OSR-1, keeping the running maximum and its index.
  - Replacement only on strictly greater, so a tie selects the lowest index.
  - After the last compare: phase ← best index, locked ← 1, state ← LOCK.
  - Samples arriving during SEL advance cnt but are otherwise ignored.
- LOCK state:
  - On din_valid with cnt==phase: sym_out ← min(din >> SHIFT, 2^SYM_W − 1) and sym_valid ← 1 in the next cycle. Latency is 1 clk from the sample cycle.
  - sym_valid is 0 in all other cycles; sym_out holds its last value.
  - Accumulators are frozen.
- restart (synchronous, any state):
  - Next cycle: cnt=0, sym_cnt=0, all acc=0, locked=0, sym_valid=0, state=ACQ.
  - phase and sym_out hold their values.
  - If din_valid is high in the same cycle, restart wins: the sample is dropped and cnt does not advance.
- No symbols are produced in ACQ or SEL. sym_valid is never asserted while locked=0.
- n_rst mid-operation returns everything to the reset values immediately.

Decomposition:
- Package rcosine_pkg holds:
  - state encoding ACQ/SEL/LOCK
  - the default constants for DW, OSR, ACQ_SYMS, MID, SHIFT, SYM_W, shared with the TX FIR
  - a clog2 helper constant function
- Sub-module rcosine_rx_slicer (combinational):
  - inputs: din
  - outputs: dev (|din−MID|) and the saturated symbol
  - instantiated once; all state and accumulation stay in the top.

Test Plan:
- Reset and steady state: hold din=MID with din_valid=1 continuously.
  - All accumulators stay 0, so phase=0 is selected.
  - locked rises 64+4 cycles after restart release.
  - The first sym_valid follows, with sym_out=MID>>15 = 2.
- Phase acquisition: repeating 4-sample pattern {MID, MID, MID+40000, MID}.
  - Result: phase=2, locked=1.
  - In LOCK, each pattern period gives sym_out=(111808>>15)=3, one strobe per 4 samples.
- Slicer boundaries: in LOCK at the chosen phase, drive din values 0, 32767, 32768, 98304, 143055.
  - Required sym_out: 0, 0, 1, 3, 3 (saturated), each exactly 1 cycle after its sample.
- din_valid gaps: the same pattern as the acquisition test with random 0–3 idle cycles between samples.
  - phase=2 is still selected.
  - Symbol count equals the number of valid samples at cnt==2 after lock.
  - sym_valid never asserts on idle cycles.
- Restart mid-lock: pulse restart coincident with din_valid while locked.
  - Next cycle: locked=0; that sample is dropped (cnt stays 0).
  - phase holds its old value until the new SEL completes.
  - Re-lock occurs after 64 more valid samples plus 4 cycles.
- Tie and async reset: all phases given equal deviation gives phase=0. Asserting n_rst during SEL clears locked, phase and sym_valid immediately, without waiting for a clk edge.
